// File: rtl/btn_press_classifier.sv
// Purpose : turns a debounced button level into press / short / long / repeat events,
//           a held level and a wrapping press counter.
// Latency : every output is registered; each event appears one edge after the sample that causes it.
// Backpr. : none; the input is a level that is sampled on every edge and all events are fire-and-forget pulses.
//
// Ports:
//   IPTCLK    clock, rising edge
//   IPTRST    synchronous active-high reset
//   IPTBTN    debounced button level (1 = pressed)
//   OUTPRESS  1-cycle pulse when a press is recognised
//   OUTSHORT  1-cycle pulse when a short press is released
//   OUTLONG   1-cycle pulse when the hold reaches LONG_CYCLES
//   OUTREPEAT 1-cycle pulse every REPEAT_CYCLES samples while a long press is held
//   OUTHELD   high while a recognised press is in progress
//   OUTCOUNT  recognised presses, modulo 2^COUNT_W
module btn_press_classifier #(
   parameter int LONG_CYCLES   = 16,
   parameter int REPEAT_CYCLES = 4,
   parameter int HOLD_W        = 8,
   parameter int COUNT_W       = 4
) (
   input  logic               IPTCLK,
   input  logic               IPTRST,
   input  logic               IPTBTN,
   output logic               OUTPRESS,
   output logic               OUTSHORT,
   output logic               OUTLONG,
   output logic               OUTREPEAT,
   output logic               OUTHELD,
   output logic [COUNT_W-1:0] OUTCOUNT
);

   localparam logic [HOLD_W-1:0] long_lim = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] rep_lim  = HOLD_W'(REPEAT_CYCLES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_t;

   state_t              state, state_n;
   logic [HOLD_W-1:0]   hold_cnt, hold_n;
   logic [HOLD_W-1:0]   rep_cnt, rep_n;
   logic                btn_q;
   logic                rise;
   logic                press_n, short_n, long_n, repeat_n, held_n;
   logic [COUNT_W-1:0]  count_n;

   assign rise = IPTBTN & ~btn_q;

   always_ff @(posedge IPTCLK) begin
      if (IPTRST) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         rep_cnt   <= '0;
         // Starting "high" means a button already held at reset release must
         // be seen low once before it can count as a press.
         btn_q     <= 1'b1;
         OUTPRESS  <= 1'b0;
         OUTSHORT  <= 1'b0;
         OUTLONG   <= 1'b0;
         OUTREPEAT <= 1'b0;
         OUTHELD   <= 1'b0;
         OUTCOUNT  <= '0;
      end else begin
         state     <= state_n;
         hold_cnt  <= hold_n;
         rep_cnt   <= rep_n;
         btn_q     <= IPTBTN;
         OUTPRESS  <= press_n;
         OUTSHORT  <= short_n;
         OUTLONG   <= long_n;
         OUTREPEAT <= repeat_n;
         OUTHELD   <= held_n;
         OUTCOUNT  <= count_n;
      end
   end

   always_comb begin
      state_n  = state;
      hold_n   = hold_cnt;
      rep_n    = rep_cnt;
      press_n  = 1'b0;
      short_n  = 1'b0;
      long_n   = 1'b0;
      repeat_n = 1'b0;
      held_n   = OUTHELD;
      count_n  = OUTCOUNT;

      unique case (state)
         IDLE: begin
            if (rise) begin
               state_n = PRESSED;
               hold_n  = {{(HOLD_W-1){1'b0}}, 1'b1};
               press_n = 1'b1;
               held_n  = 1'b1;
               count_n = OUTCOUNT + 1'b1;
            end
         end
         PRESSED: begin
            if (IPTBTN) begin
               hold_n = hold_cnt + 1'b1;
               if (hold_n == long_lim) begin
                  state_n = LONG;
                  long_n  = 1'b1;
                  rep_n   = '0;
               end
            end else begin
               // A release on the edge that would have reached the long
               // threshold lands here, so it is still a short press.
               state_n = IDLE;
               short_n = 1'b1;
               held_n  = 1'b0;
            end
         end
         LONG: begin
            // hold_cnt is frozen here, so a long hold can last indefinitely.
            if (IPTBTN) begin
               if (REPEAT_CYCLES != 0) begin
                  rep_n = rep_cnt + 1'b1;
                  if (rep_n == rep_lim) begin
                     repeat_n = 1'b1;
                     rep_n    = '0;
                  end
               end
            end else begin
               state_n = IDLE;
               held_n  = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
            held_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Purpose : drives two classifiers (repeat every 4, repeat disabled) with directed and random button traffic.
// Latency : outputs compared against a run-length reference model half a clock after each edge.
// Backpr. : none.
module tb_btn_press_classifier;

   localparam int LONG_C = 16;
   localparam int CNT_W  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn = 1'b0;

   logic [1:0]       press_w, short_w, long_w, rep_w, held_w;
   logic [CNT_W-1:0] count_w [2];

   always #5 clk = ~clk;

   btn_press_classifier #(.LONG_CYCLES(LONG_C), .REPEAT_CYCLES(4), .HOLD_W(8), .COUNT_W(CNT_W)) dut_rep (
      .IPTCLK(clk), .IPTRST(rst), .IPTBTN(btn),
      .OUTPRESS(press_w[0]), .OUTSHORT(short_w[0]), .OUTLONG(long_w[0]),
      .OUTREPEAT(rep_w[0]), .OUTHELD(held_w[0]), .OUTCOUNT(count_w[0]));

   btn_press_classifier #(.LONG_CYCLES(LONG_C), .REPEAT_CYCLES(0), .HOLD_W(8), .COUNT_W(CNT_W)) dut_norep (
      .IPTCLK(clk), .IPTRST(rst), .IPTBTN(btn),
      .OUTPRESS(press_w[1]), .OUTSHORT(short_w[1]), .OUTLONG(long_w[1]),
      .OUTREPEAT(rep_w[1]), .OUTHELD(held_w[1]), .OUTCOUNT(count_w[1]));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: tracks how many consecutive high samples the current
   // press has lasted and derives every event from that length.
   int  rep_per [2] = '{4, 0};
   int  run     [2];
   bit  held_m  [2];
   int  cnt_m   [2];
   bit  prev_m = 1'b1;
   bit  e_press [2], e_short [2], e_long [2], e_rep [2];

   // Event tallies observed on the DUTs, cleared per directed segment.
   int  t_press [2], t_short [2], t_long [2], t_rep [2];

   task automatic model_step(input bit b, input bit r);
      for (int k = 0; k < 2; k++) begin
         e_press[k] = 0; e_short[k] = 0; e_long[k] = 0; e_rep[k] = 0;
         if (r) begin
            held_m[k] = 0; run[k] = 0; cnt_m[k] = 0;
         end else if (held_m[k]) begin
            if (b) begin
               run[k]++;
               if (run[k] == LONG_C)
                  e_long[k] = 1;
               else if (rep_per[k] != 0 && run[k] > LONG_C && ((run[k] - LONG_C) % rep_per[k]) == 0)
                  e_rep[k] = 1;
            end else begin
               if (run[k] < LONG_C) e_short[k] = 1;
               held_m[k] = 0;
            end
         end else if (b && !prev_m) begin
            e_press[k] = 1;
            held_m[k]  = 1;
            run[k]     = 1;
            cnt_m[k]   = (cnt_m[k] + 1) % (1 << CNT_W);
         end
      end
      prev_m = r ? 1'b1 : b;
   endtask

   task automatic clear_tally();
      for (int k = 0; k < 2; k++) begin
         t_press[k] = 0; t_short[k] = 0; t_long[k] = 0; t_rep[k] = 0;
      end
   endtask

   task automatic cycle(input bit b, input bit r);
      btn = b;
      rst = r;
      @(posedge clk);
      model_step(b, r);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("press%0d", k),  press_w[k], e_press[k]);
         chk($sformatf("short%0d", k),  short_w[k], e_short[k]);
         chk($sformatf("long%0d", k),   long_w[k],  e_long[k]);
         chk($sformatf("repeat%0d", k), rep_w[k],   e_rep[k]);
         chk($sformatf("held%0d", k),   held_w[k],  held_m[k]);
         chk($sformatf("count%0d", k),  count_w[k], cnt_m[k]);
         t_press[k] += press_w[k];
         t_short[k] += short_w[k];
         t_long[k]  += long_w[k];
         t_rep[k]   += rep_w[k];
      end
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
   endtask

   initial begin
      @(negedge clk);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      chk("reset_count", count_w[0], 0);
      chk("reset_held", held_w[0], 0);
      cycle(1'b0, 1'b0);

      // Five-sample press.
      clear_tally();
      hold(5);
      cycle(1'b0, 1'b0);
      chk("p5_press", t_press[0], 1);
      chk("p5_short", t_short[0], 1);
      chk("p5_long", t_long[0], 0);
      chk("p5_count", count_w[0], 1);

      // One sample short of the long threshold, then exactly at it.
      clear_tally();
      hold(15);
      chk("p15_short", t_short[0], 1);
      chk("p15_long", t_long[0], 0);
      clear_tally();
      hold(16);
      chk("p16_short", t_short[0], 0);
      chk("p16_long", t_long[0], 1);

      // Long hold with repeats.
      clear_tally();
      hold(30);
      chk("p30_long", t_long[0], 1);
      chk("p30_rep", t_rep[0], 3);
      chk("p30_rep_off", t_rep[1], 0);
      chk("p30_short", t_short[0], 0);

      // Button held high across reset release.
      clear_tally();
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
      chk("rsthi_press", t_press[0], 0);
      chk("rsthi_count", count_w[0], 0);
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      chk("rsthi_press2", t_press[0], 1);
      chk("rsthi_count2", count_w[0], 1);
      cycle(1'b0, 1'b0);

      // 17 back-to-back presses wrap the counter.
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      clear_tally();
      for (int i = 0; i < 17; i++) hold(2);
      chk("b2b_press", t_press[0], 17);
      chk("b2b_short", t_short[0], 17);
      chk("b2b_count", count_w[0], 1);

      // Reset on the tenth high sample of a hold.
      clear_tally();
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      chk("rstmid_held", held_w[0], 0);
      chk("rstmid_count", count_w[0], 0);
      clear_tally();
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
      chk("rstmid_press", t_press[0], 0);
      chk("rstmid_long", t_long[0], 0);
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      chk("rstmid_press2", t_press[0], 1);
      cycle(1'b0, 1'b0);

      // Random runs of highs and lows with occasional resets.
      for (int s = 0; s < 300; s++) begin
         bit lvl;
         int len;
         lvl = 1'($urandom_range(0, 1));
         len = (s % 3 == 0) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
         for (int i = 0; i < len; i++)
            cycle(lvl, ($urandom_range(0, 199) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
